// File: rtl/afifo_wr_ctrl.sv
// Write-side controller of the async FIFO: valid/ready intake, RAM write port,
// binary/Gray write pointer, and read-pointer sync for full/almost-full/overflow.
module afifo_wr_ctrl #(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 8,
   parameter int AF_THRESH = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic [ADDR_W:0]   rptr_gray_in,
   output logic [ADDR_W:0]   wptr_gray,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              full,
   output logic              almost_full,
   output logic              overflow,
   input  logic              ovf_clr
);
   localparam int PW = ADDR_W + 1;

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [PW-1:0] wbin, wbin_nxt, wgray_nxt;
   logic [PW-1:0] rq1, rq2, rbin, level, full_pat;
   logic          push;

   assign push      = wr_valid & ~full;
   assign wbin_nxt  = wbin + PW'(push);
   assign wgray_nxt = wbin_nxt ^ (wbin_nxt >> 1);

   // Full pattern: same low bits as the read pointer, top two Gray bits inverted.
   assign full_pat  = {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]};
   assign rbin      = gray2bin(rq2);
   assign level     = wbin_nxt - rbin;

   assign wr_ready  = ~full;
   assign mem_we    = push;
   assign mem_waddr = wbin[ADDR_W-1:0];
   assign mem_wdata = wr_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbin        <= '0;
         wptr_gray   <= '0;
         rq1         <= '0;
         rq2         <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         wbin        <= wbin_nxt;
         wptr_gray   <= wgray_nxt;
         rq1         <= rptr_gray_in;
         rq2         <= rq1;
         full        <= (wgray_nxt == full_pat);
         almost_full <= (level >= PW'(AF_THRESH));
         // Set wins over clear so a rejected write is never lost.
         if (wr_valid & full) overflow <= 1'b1;
         else if (ovf_clr)    overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Directed bench for afifo_wr_ctrl: fill to full, overflow, release, wrap, reset.
module tb_afifo_wr_ctrl;
   logic       clk = 1'b0;
   logic       rst, wr_valid, wr_ready, mem_we, full, almost_full, overflow, ovf_clr;
   logic [7:0] wr_data, mem_wdata;
   logic [4:0] rptr_gray_in, wptr_gray, prev_g;
   logic [3:0] mem_waddr;
   logic [7:0] ram [16];
   int errs = 0, checks = 0;

   always #5 clk = ~clk;

   afifo_wr_ctrl #(.ADDR_W(4), .DATA_W(8), .AF_THRESH(12)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rptr_gray_in(rptr_gray_in), .wptr_gray(wptr_gray), .mem_we(mem_we),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .full(full),
      .almost_full(almost_full), .overflow(overflow), .ovf_clr(ovf_clr));

   // RAM model capturing the write port on the accept edge
   always @(posedge clk) if (mem_we) ram[mem_waddr] <= mem_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] gray5(input int b);
      logic [4:0] v;
      v = 5'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; wr_valid = 1'b0; ovf_clr = 1'b0; rptr_gray_in = '0; wr_data = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_valid = 1'b0; ovf_clr = 1'b0; rptr_gray_in = '0; wr_data = '0;
      #12;
      chk("rst_wptr", 32'(wptr_gray), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_af", 32'(almost_full), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_ready", 32'(wr_ready), 1);
      do_reset();

      // Fill 16 entries; almost_full edge at 12th accept, full at 16th
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         wr_valid = 1'b1; wr_data = 8'(i);
         #1;
         chk("fill_waddr", 32'(mem_waddr), 32'(i));
         chk("fill_we", 32'(mem_we), 1);
         chk("fill_wdata", 32'(mem_wdata), 32'(i));
         @(posedge clk); #1;
         if (i == 10) chk("af_11", 32'(almost_full), 0);
         if (i == 11) chk("af_12", 32'(almost_full), 1);
         if (i == 14) chk("full_15", 32'(full), 0);
      end
      chk("full_16", 32'(full), 1);
      chk("ready_16", 32'(wr_ready), 0);
      chk("wptr_16", 32'(wptr_gray), 32'h18);

      // Overflow: rejected write, clear, set-wins
      @(negedge clk);
      wr_valid = 1'b1; wr_data = 8'hAA;
      #1 chk("ovf_we", 32'(mem_we), 0);
      @(posedge clk); #1;
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_wptr", 32'(wptr_gray), 32'h18);
      @(negedge clk);
      wr_valid = 1'b0; ovf_clr = 1'b1;
      @(posedge clk); #1;
      chk("ovf_clr", 32'(overflow), 0);
      @(negedge clk);
      wr_valid = 1'b1;
      @(posedge clk); #1;
      chk("ovf_setwins", 32'(overflow), 1);
      @(negedge clk);
      wr_valid = 1'b0;
      @(posedge clk); #1;
      chk("ovf_clr2", 32'(overflow), 0);

      // Release: read pointer advances by one, full drops on 3rd edge
      @(negedge clk);
      ovf_clr = 1'b0; rptr_gray_in = 5'b00001;
      @(posedge clk); #1;
      chk("rel_e1", 32'(full), 1);
      @(posedge clk); #1;
      chk("rel_e2", 32'(full), 1);
      @(posedge clk); #1;
      chk("rel_e3", 32'(full), 0);
      @(negedge clk);
      wr_valid = 1'b1; wr_data = 8'h55;
      #1;
      chk("rel_we", 32'(mem_we), 1);
      chk("rel_waddr", 32'(mem_waddr), 0);
      @(posedge clk); #1;
      chk("rel_full", 32'(full), 1);
      chk("rel_wptr", 32'(wptr_gray), 32'h19);
      chk("rel_ram0", 32'(ram[0]), 32'h55);

      // 40 writes, read pointer trailing by 4: wrap, single-bit Gray steps, order
      do_reset();
      prev_g = wptr_gray;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         wr_valid = 1'b1; wr_data = 8'(8'h30 + i);
         rptr_gray_in = gray5((i >= 4) ? i - 4 : 0);
         #1;
         chk("wrap_waddr", 32'(mem_waddr), 32'(i % 16));
         if (i >= 4) chk("wrap_order", 32'(ram[(i - 4) % 16]), 32'(8'h30 + i - 4));
         @(posedge clk); #1;
         chk("wrap_wptr", 32'(wptr_gray), 32'(gray5((i + 1) % 32)));
         chk("wrap_1bit", 32'($countones(wptr_gray ^ prev_g)), 1);
         chk("wrap_nofull", 32'(full), 0);
         prev_g = wptr_gray;
      end

      // Asynchronous reset mid-cycle after 7 writes
      do_reset();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         wr_valid = 1'b1; wr_data = 8'(i);
         @(posedge clk);
      end
      #1 chk("pre_rst_wptr", 32'(wptr_gray), 32'h04);
      @(negedge clk);
      wr_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_wptr", 32'(wptr_gray), 0);
      chk("arst_ready", 32'(wr_ready), 1);
      chk("arst_full", 32'(full), 0);
      chk("arst_waddr", 32'(mem_waddr), 0);
      #1 rst = 1'b0;
      @(negedge clk);
      wr_valid = 1'b1; wr_data = 8'h77;
      #1 chk("post_rst_waddr", 32'(mem_waddr), 0);
      @(posedge clk); #1;
      chk("post_rst_wptr", 32'(wptr_gray), 32'h01);
      @(negedge clk);
      wr_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
